instr_fetch_seq: RTL

Instruction fetch and sequencing stage that sits directly downstream of the 7-slot, 256-bit `memory` block. It reads the packed 32-byte instruction word from the instruction slot over the shared tristate `dataBus` and holds it in an internal register. It then decodes one byte at a time and issues the decoded instructions in order to the matrix execution unit over a valid/ready handshake. It stops on a STOP/NO_OP byte or after instruction 31.

---
 rtl/instr_fetch_seq.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction fetch and sequencing stage.
// Reads the 256-bit instruction word from one memory slot over the shared
// data bus, then issues its bytes in order (most significant byte first)
// to the execution unit over a valid/ready handshake. The run stops on a
// STOP (8'h00) byte or after the last instruction byte is accepted.
module instr_fetch_seq #(
    parameter logic [2:0] INSTR_ADDR = 3'd2,
    parameter logic [4:0] LAST_PC    = 5'd31
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         start,
    input  logic [255:0] dataBus,
    output logic [2:0]   mem_address,
    output logic         mem_nEnable,
    output logic         mem_ReadWrite,
    output logic         mem_own,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [2:0]   opcode,
    output logic [1:0]   dest,
    output logic [2:0]   maddr,
    output logic [4:0]   imm,
    output logic [4:0]   pc,
    output logic         busy,
    output logic         halted
);

    localparam int unsigned IR_W   = 256;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PC_W   = 5;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned DEST_W = 2;
    localparam int unsigned MA_W   = 3;
    localparam int unsigned IMM_W  = 5;

    localparam logic [BYTE_W-1:0] STOP_BYTE = BYTE_W'(8'h00);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_REQ = 3'd1,
        S_FETCH_CAP = 3'd2,
        S_ISSUE     = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    // Selects instruction byte idx; byte 0 is the most significant byte.
    function automatic logic [BYTE_W-1:0] sel_byte(
        input logic [IR_W-1:0] ir,
        input logic [PC_W-1:0] idx
    );
        logic [IR_W-1:0] shifted;
        shifted = ir << {idx, 3'b000};
        return shifted[IR_W-1 -: BYTE_W];
    endfunction

    // Sequencer state and datapath registers
    state_t              r_state;
    logic [IR_W-1:0]     r_ir;
    logic [PC_W-1:0]     r_pc;

    // Registered outputs
    logic [ADDR_W-1:0]   r_mem_address;
    logic                r_mem_nEnable;
    logic                r_mem_own;
    logic                r_instr_valid;
    logic [OP_W-1:0]     r_opcode;
    logic [DEST_W-1:0]   r_dest;
    logic [MA_W-1:0]     r_maddr;
    logic [IMM_W-1:0]    r_imm;
    logic                r_busy;
    logic                r_halted;

    // Next-state values
    state_t              w_state_nxt;
    logic [IR_W-1:0]     w_ir_nxt;
    logic [PC_W-1:0]     w_pc_nxt;
    logic [BYTE_W-1:0]   w_cur_byte;
    logic [BYTE_W-1:0]   w_nxt_byte;
    logic                w_fetch_nxt;
    logic                w_valid_nxt;
    logic [ADDR_W-1:0]   w_mem_address_nxt;
    logic                w_mem_nEnable_nxt;
    logic                w_mem_own_nxt;
    logic [OP_W-1:0]     w_opcode_nxt;
    logic [DEST_W-1:0]   w_dest_nxt;
    logic [MA_W-1:0]     w_maddr_nxt;
    logic [IMM_W-1:0]    w_imm_nxt;
    logic                w_busy_nxt;
    logic                w_halted_nxt;

    assign w_cur_byte = sel_byte(r_ir, r_pc);

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, program counter and instruction register update
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH_REQ;
                    w_pc_nxt    = '0;
                end
            end
            S_FETCH_REQ: begin
                w_state_nxt = S_FETCH_CAP;
            end
            S_FETCH_CAP: begin
                w_ir_nxt    = dataBus;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_cur_byte == STOP_BYTE) begin
                    w_state_nxt = S_HALT;
                end else if (r_instr_valid && instr_ready) begin
                    if (r_pc == LAST_PC) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    w_state_nxt = S_FETCH_REQ;
                    w_pc_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, so every output is a flop
    always_comb begin
        w_fetch_nxt       = 1'b0;
        w_valid_nxt       = 1'b0;
        w_nxt_byte        = '0;
        w_mem_address_nxt = '0;
        w_mem_nEnable_nxt = 1'b1;
        w_mem_own_nxt     = 1'b0;
        w_opcode_nxt      = '0;
        w_dest_nxt        = '0;
        w_maddr_nxt       = '0;
        w_imm_nxt         = '0;
        w_busy_nxt        = 1'b0;
        w_halted_nxt      = 1'b0;

        w_fetch_nxt = (w_state_nxt == S_FETCH_REQ) || (w_state_nxt == S_FETCH_CAP);
        w_nxt_byte  = sel_byte(w_ir_nxt, w_pc_nxt);
        w_valid_nxt = (w_state_nxt == S_ISSUE) && (w_nxt_byte != STOP_BYTE);

        if (w_fetch_nxt) begin
            w_mem_own_nxt     = 1'b1;
            w_mem_nEnable_nxt = 1'b0;
            w_mem_address_nxt = INSTR_ADDR;
        end

        if (w_valid_nxt) begin
            w_opcode_nxt = w_nxt_byte[7:5];
            w_dest_nxt   = w_nxt_byte[4:3];
            w_maddr_nxt  = w_nxt_byte[2:0];
            w_imm_nxt    = w_nxt_byte[4:0];
        end

        w_busy_nxt   = w_fetch_nxt || (w_state_nxt == S_ISSUE);
        w_halted_nxt = (w_state_nxt == S_HALT);
    end

    // Datapath and output registers; reset releases the bus immediately
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_ir          <= '0;
            r_pc          <= '0;
            r_mem_address <= '0;
            r_mem_nEnable <= 1'b1;
            r_mem_own     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_opcode      <= '0;
            r_dest        <= '0;
            r_maddr       <= '0;
            r_imm         <= '0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_ir          <= w_ir_nxt;
            r_pc          <= w_pc_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_nEnable <= w_mem_nEnable_nxt;
            r_mem_own     <= w_mem_own_nxt;
            r_instr_valid <= w_valid_nxt;
            r_opcode      <= w_opcode_nxt;
            r_dest        <= w_dest_nxt;
            r_maddr       <= w_maddr_nxt;
            r_imm         <= w_imm_nxt;
            r_busy        <= w_busy_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    // This stage only ever reads memory
    assign mem_ReadWrite = 1'b1;

    assign mem_address = r_mem_address;
    assign mem_nEnable = r_mem_nEnable;
    assign mem_own     = r_mem_own;
    assign instr_valid = r_instr_valid;
    assign opcode      = r_opcode;
    assign dest        = r_dest;
    assign maddr       = r_maddr;
    assign imm         = r_imm;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign halted      = r_halted;

endmodule
